_64b66b_tx: RTL and testbench
=============================

_64B66B_TX -- requirements
Module: _64b66b_tx

Interface
REQ-001 SHALL have parameter LEN, default 64: scrambled payload width in bits, legal range 1..264.
REQ-002 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port nreset  input  1: reset is asynchronous and active-low.
REQ-004 SHALL have port valid_i  input  1: upstream block valid.
REQ-005 SHALL have port ready_o  output  1: block accepts upstream block this cycle.
REQ-006 SHALL have port head_i  input  2: sync header, passed through unscrambled.
REQ-007 SHALL have port data_i  input  LEN: unscrambled payload, bit 0 transmitted first.
REQ-008 SHALL have port valid_o  output  1: downstream block valid.
REQ-009 SHALL have port ready_i  input  1: downstream accepts block.
REQ-010 SHALL have port head_o  output  2: registered sync header.
REQ-011 SHALL have port data_o  output  LEN: registered scrambled payload.

Function
REQ-012 SHALL scramble per G(x)=1+x^39+x^58: s[i] = d[i] ^ s[i-39] ^ s[i-58], in transmit bit order.
REQ-013 SHALL keep a 58-bit state of previously emitted scrambled bits; state[0] = most recent bit, state[k] = bit emitted k+1 bits earlier.
REQ-014 SHALL use state[-j-1] for any reference s[j] with j<0 inside the current block.
REQ-015 SHALL, on acceptance, load state[k] = s[LEN-1-k] for k<LEN and state[k] = old state[k-LEN] for k>=LEN.
REQ-016 SHALL accept an input block when valid_i && ready_o, with ready_o = ~valid_o | ready_i.
REQ-017 SHALL advance scrambler state only on an accepted block; idle or stalled cycles leave state unchanged.
REQ-018 SHALL present the accepted block on head_o/data_o with valid_o=1 exactly one cycle after acceptance (latency 1).
REQ-019 SHALL hold valid_o, head_o and data_o stable while valid_o && ~ready_i.
REQ-020 SHALL clear valid_o after a downstream transfer when no new block is accepted in the same cycle.
REQ-021 SHALL sustain one block per cycle when valid_i and ready_i are held high.
REQ-022 SHALL produce output that descrambles back to data_i via the team's descrambler in the same LEN configuration.

Reset
REQ-023 SHALL, while nreset=0, force state to all ones (58'h3FF_FFFF_FFFF_FFFF).
REQ-024 SHALL, while nreset=0, force valid_o=0, head_o=2'b00 and data_o=0.
REQ-025 SHALL, on reset mid-stream, discard any held output block; the first block after release is scrambled from the all-ones seed.

Configuration
REQ-026 SHALL compile a test-pattern mode, plus input port test_i (1 bit), only when macro SCRAM_TEST_PATTERN_EN is defined.
REQ-027 SHALL, with the macro defined and test_i=1:
- force ready_o=0
- self-generate one block per cycle whenever ready_o would otherwise be 1
- scramble an all-zero payload
- set head_o=2'b01
REQ-028 SHALL, with the macro defined and test_i=0, behave exactly as without the macro.
REQ-029 SHALL, without the macro, have no test_i port and no test-pattern logic.

Verification
REQ-030 Zero seed check: release reset, LEN=64, accept data_i=0, head_i=2'b01 -> next cycle valid_o=1, head_o=2'b01, data_o=64'h03FF_FF80_0000_0000.
REQ-031 Backpressure: hold ready_i=0 with valid_o=1 for 5 cycles while valid_i=1 -> ready_o=0 and outputs constant; after ready_i=1, the next block is scrambled from the state after the first block only.
REQ-032 Round trip: stream 1000 random blocks at full rate into the team's descrambler (LEN=64) -> recovered payloads equal the inputs, in order.
REQ-033 Reset mid-stream: assert nreset low asynchronously with valid_o=1 -> valid_o=0 immediately; after release, data_i=0 again yields 64'h03FF_FF80_0000_0000.
REQ-034 Narrow width: LEN=16, feed four zero blocks -> concatenated output equals the LEN=64 zero-block result of REQ-030.
REQ-035 Test pattern: with SCRAM_TEST_PATTERN_EN defined, test_i=1, ready_i=1 -> ready_o=0, a valid block every cycle, first data_o=64'h03FF_FF80_0000_0000, head_o=2'b01.

Source files
------------

// File: rtl/_64b66b_tx.sv
// _64b66b_tx: 64b/66b transmit scrambler (G(x)=1+x^39+x^58) with a one-deep valid/ready output register.
// Define SCRAM_TEST_PATTERN_EN to add test_i and a self-generated all-zero test-pattern mode.
module _64b66b_tx #(
  parameter int LEN = 64
) (
  input  logic           clk,
  input  logic           nreset,
`ifdef SCRAM_TEST_PATTERN_EN
  input  logic           test_i,
`endif
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [1:0]     head_i,
  input  logic [LEN-1:0] data_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [1:0]     head_o,
  output logic [LEN-1:0] data_o
);

  localparam int SW = 58;

  logic [SW-1:0]  state_q, state_d, state_nxt;
  logic           valid_q, valid_d;
  logic [1:0]     head_q, head_d;
  logic [LEN-1:0] data_q, data_d, scr_data;
  logic           ready_int, blk_vld, accept;
  logic [1:0]     blk_head;
  logic [LEN-1:0] blk_data;

  // Returns {next state, scrambled block}. ext[j+SW] holds s[j], so j<0 reads the saved state.
  function automatic logic [SW+LEN-1:0] scramble(input logic [LEN-1:0] d, input logic [SW-1:0] st);
    logic [LEN+SW-1:0] ext;
    logic [SW-1:0]     nst;
    for (int m = 0; m < SW; m++) ext[m] = st[SW-1-m];
    for (int i = 0; i < LEN; i++) ext[i+SW] = d[i] ^ ext[i+SW-39] ^ ext[i];
    for (int k = 0; k < SW; k++) nst[k] = ext[LEN+SW-1-k];
    return {nst, ext[LEN+SW-1:SW]};
  endfunction

  always_comb begin
    ready_int = ~valid_q | ready_i;
    ready_o   = ready_int;
    blk_vld   = valid_i;
    blk_head  = head_i;
    blk_data  = data_i;
`ifdef SCRAM_TEST_PATTERN_EN
    if (test_i) begin
      ready_o  = 1'b0;
      blk_vld  = 1'b1;
      blk_head = 2'b01;
      blk_data = '0;
    end
`endif
    accept = blk_vld & ready_int;
  end

  assign {state_nxt, scr_data} = scramble(blk_data, state_q);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q & ~ready_i;
    head_d  = head_q;
    data_d  = data_q;
    if (accept) begin
      state_d = state_nxt;
      valid_d = 1'b1;
      head_d  = blk_head;
      data_d  = scr_data;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= '1;
      valid_q <= 1'b0;
      head_q  <= 2'b00;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb__64b66b_tx.sv
// Bench for _64b66b_tx: directed table, backpressure/reset sequences, random traffic against a
// bit-stream scrambler/descrambler model, and a LEN=16 instance for stream continuity.
module tb__64b66b_tx;

  localparam logic [63:0] ZERO_BLK = 64'h03FF_FF80_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic        valid_i, ready_i, ready_o, valid_o;
  logic [1:0]  head_i, head_o;
  logic [63:0] data_i, data_o;
  logic        v16_i, r16_i, r16_o, v16_o;
  logic [1:0]  h16_i, h16_o;
  logic [15:0] d16_i, d16_o;
`ifdef SCRAM_TEST_PATTERN_EN
  logic        test_i;
  logic        test16_i;
`endif

  _64b66b_tx #(.LEN(64)) dut (
    .clk(clk), .nreset(nreset),
`ifdef SCRAM_TEST_PATTERN_EN
    .test_i(test_i),
`endif
    .valid_i(valid_i), .ready_o(ready_o), .head_i(head_i), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .head_o(head_o), .data_o(data_o)
  );

  _64b66b_tx #(.LEN(16)) dut16 (
    .clk(clk), .nreset(nreset),
`ifdef SCRAM_TEST_PATTERN_EN
    .test_i(test16_i),
`endif
    .valid_i(v16_i), .ready_o(r16_o), .head_i(h16_i), .data_i(d16_i),
    .valid_o(v16_o), .ready_i(r16_i), .head_o(h16_o), .data_o(d16_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference: transmitted and received scrambled bit streams, oldest bit first, last 58 kept.
  bit          tx_hist[$];
  bit          rx_hist[$];
  logic [63:0] sent_q[$];
  bit          m_valid;
  logic [1:0]  m_head;
  logic [63:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_scramble(input logic [63:0] d);
    logic [63:0] s;
    for (int i = 0; i < 64; i++) begin
      s[i] = d[i] ^ tx_hist[tx_hist.size()-39] ^ tx_hist[tx_hist.size()-58];
      tx_hist.push_back(s[i]);
      void'(tx_hist.pop_front());
    end
    return s;
  endfunction

  function automatic logic [63:0] model_descramble(input logic [63:0] s);
    logic [63:0] d;
    for (int i = 0; i < 64; i++) begin
      d[i] = s[i] ^ rx_hist[rx_hist.size()-39] ^ rx_hist[rx_hist.size()-58];
      rx_hist.push_back(s[i]);
      void'(rx_hist.pop_front());
    end
    return d;
  endfunction

  task automatic model_reset();
    tx_hist.delete();
    rx_hist.delete();
    for (int i = 0; i < 58; i++) begin
      tx_hist.push_back(1'b1);
      rx_hist.push_back(1'b1);
    end
    sent_q.delete();
    m_valid = 1'b0;
    m_head  = 2'b00;
    m_data  = '0;
  endtask

  task automatic do_reset();
    nreset  = 1'b0;
    valid_i = 1'b0; ready_i = 1'b1; head_i = 2'b00; data_i = '0;
    v16_i   = 1'b0; r16_i = 1'b1; h16_i = 2'b00; d16_i = '0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_head_o", 64'(head_o), 64'd0);
    check("rst_data_o", data_o, 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  // One clock cycle on the LEN=64 instance; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit v, input bit r, input logic [1:0] h, input logic [63:0] d,
                       output bit rdy_seen);
    bit m_ready, acc, xfer;
    logic [63:0] exp_in;
    valid_i = v; ready_i = r; head_i = h; data_i = d;
    #1;
    rdy_seen = ready_o;
    m_ready  = !m_valid || r;
    check("ready_o", 64'(ready_o), 64'(m_ready));
    acc  = v && m_ready;
    xfer = m_valid && r;
    if (xfer) begin
      if (sent_q.size() == 0) begin
        check("roundtrip_underflow", 64'd1, 64'd0);
      end else begin
        exp_in = sent_q.pop_front();
        check("roundtrip", model_descramble(data_o), exp_in);
      end
    end
    if (acc) sent_q.push_back(d);
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1;
      m_head  = h;
      m_data  = model_scramble(d);
    end else if (r) begin
      m_valid = 1'b0;
    end
    #1;
    check("valid_o", 64'(valid_o), 64'(m_valid));
    if (m_valid) begin
      check("head_o", 64'(head_o), 64'(m_head));
      check("data_o", data_o, m_data);
    end
  endtask

  typedef struct {
    bit          v;
    bit          r;
    logic [1:0]  h;
    logic [63:0] d;
    bit          exp_rdy;
    bit          exp_vld;
    bit          chk_d;
    logic [1:0]  exp_h;
    logic [63:0] exp_d;
  } vec_t;

  vec_t        vecs[9];
  bit          rdy;
  logic [63:0] out_a;
  logic [1:0]  head_a;
  logic [63:0] blk_a, blk_b;
  logic [15:0] pieces[4];
  logic [63:0] cat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef SCRAM_TEST_PATTERN_EN
    test_i   = 1'b0;
    test16_i = 1'b0;
`endif
    vecs[0] = '{1'b1, 1'b1, 2'b01, 64'h0, 1'b1, 1'b1, 1'b1, 2'b01, ZERO_BLK};
    vecs[1] = '{1'b0, 1'b1, 2'b00, 64'h0, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0};
    vecs[2] = '{1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0};
    vecs[3] = '{1'b1, 1'b0, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 1'b0, 2'b10, 64'h0};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 2'b10, 64'h0};
    vecs[5] = '{1'b0, 1'b1, 2'b00, 64'h0, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0};
    vecs[6] = '{1'b1, 1'b1, 2'b10, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1, 1'b0, 2'b10, 64'h0};
    vecs[7] = '{1'b1, 1'b1, 2'b01, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 2'b01, 64'h0};
    vecs[8] = '{1'b0, 1'b1, 2'b00, 64'h0, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].v, vecs[i].r, vecs[i].h, vecs[i].d, rdy);
      check($sformatf("vec%0d_ready", i), 64'(rdy), 64'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_valid", i), 64'(valid_o), 64'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) check($sformatf("vec%0d_head", i), 64'(head_o), 64'(vecs[i].exp_h));
      if (vecs[i].chk_d) check($sformatf("vec%0d_data", i), data_o, vecs[i].exp_d);
    end

    // Backpressure: output held, state advanced by the first block only.
    do_reset();
    blk_a = {$urandom(), $urandom()};
    blk_b = {$urandom(), $urandom()};
    cycle(1'b1, 1'b1, 2'b01, blk_a, rdy);
    out_a  = data_o;
    head_a = head_o;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 2'b10, blk_b, rdy);
      check("bp_ready_low", 64'(rdy), 64'd0);
      check("bp_valid_hold", 64'(valid_o), 64'd1);
      check("bp_data_hold", data_o, out_a);
      check("bp_head_hold", 64'(head_o), 64'(head_a));
    end
    cycle(1'b1, 1'b1, 2'b10, blk_b, rdy);
    check("bp_ready_release", 64'(rdy), 64'd1);
    check("bp_second_head", 64'(head_o), 64'(2'b10));
    cycle(1'b0, 1'b1, 2'b00, 64'h0, rdy);

    // Asynchronous reset in mid-stream.
    cycle(1'b1, 1'b0, 2'b01, {$urandom(), $urandom()}, rdy);
    #2 nreset = 1'b0;
    #1;
    check("async_rst_valid", 64'(valid_o), 64'd0);
    check("async_rst_data", data_o, 64'd0);
    check("async_rst_head", 64'(head_o), 64'd0);
    do_reset();
    cycle(1'b1, 1'b1, 2'b01, 64'h0, rdy);
    check("post_rst_zero_blk", data_o, ZERO_BLK);

    // Full-rate random stream, then random handshakes.
    for (int i = 0; i < 1000; i++)
      cycle(1'b1, 1'b1, 2'($urandom_range(1, 2)), {$urandom(), $urandom()}, rdy);
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(1, 2)),
            {$urandom(), $urandom()}, rdy);
    cycle(1'b0, 1'b1, 2'b00, 64'h0, rdy);
    check("roundtrip_drained", 64'(sent_q.size()), 64'd0);

    // LEN=16: four zero blocks continue one bit stream.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      v16_i = 1'b1; r16_i = 1'b1; h16_i = 2'b01; d16_i = '0;
      @(posedge clk);
      #1;
      check($sformatf("len16_valid%0d", k), 64'(v16_o), 64'd1);
      pieces[k] = d16_o;
    end
    v16_i = 1'b0;
    cat = {pieces[3], pieces[2], pieces[1], pieces[0]};
    check("len16_concat", cat, ZERO_BLK);

`ifdef SCRAM_TEST_PATTERN_EN
    do_reset();
    test_i = 1'b1; ready_i = 1'b1; valid_i = 1'b0;
    #1;
    check("tp_ready_o", 64'(ready_o), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("tp_valid", 64'(valid_o), 64'd1);
      check("tp_head", 64'(head_o), 64'(2'b01));
      check("tp_ready_o_run", 64'(ready_o), 64'd0);
      if (k == 0) check("tp_first_data", data_o, ZERO_BLK);
    end
    test_i = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
